// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the four-core data-memory arbiter: FSM state
// encoding and the default geometry of the core/RAM interface.
package dmem_arb_pkg;

  localparam int NCORES_DEF = 4;
  localparam int AW_DEF     = 8;
  localparam int DW_DEF     = 8;

  // FREE: idle, sampling requests. ISSUE: RAM sees address (and write strobe).
  // WAITQ: read data arrives from RAM. DONE: completion pulse to the winner.
  typedef enum logic [1:0] {
    FREE  = 2'd0,
    ISSUE = 2'd1,
    WAITQ = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: scans the request vector starting at ptr and wrapping
// modulo N, returning a one-hot grant for the first requester found.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  // Walk the N candidates in priority order ptr, ptr+1, ... and take the first.
  always_comb begin
    int          sum;
    logic [PW-1:0] idx;
    grant = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr) + k;
      if (sum >= N) sum = sum - N;
      idx = PW'(sum);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter4.sv
// Arbiter that shares one single-port synchronous RAM among NCORES cores.
// One access is in flight at a time; the winner is chosen round-robin.
//
// Core handshake: core i raises rden[i] and/or wren[i] (both = write) with its
// Address/Din slice held stable while the arbiter is FREE. The request is
// latched on the edge at the end of a FREE cycle and later inputs are ignored
// until completion. acq[i] pulses for exactly one cycle when the access is
// complete (read data already on Dq); the core must drop its request in the
// following cycle or it will be seen as a new request.
module dmem_arbiter4
  import dmem_arb_pkg::*;
#(
  parameter int NCORES = NCORES_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    rden,
  input  logic [NCORES-1:0]    wren,
  input  logic [NCORES*AW-1:0] Address,
  input  logic [NCORES*DW-1:0] Din,
  input  logic [DW-1:0]        RAMq,
  output logic [NCORES-1:0]    acq,
  output logic [DW-1:0]        Dq,
  output logic                 busy,
  output logic [AW-1:0]        RAMAddress,
  output logic [DW-1:0]        RAMDin,
  output logic                 RAMwren,
  output logic [1:0]           dbg_state
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

  state_t              state;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       g;
  logic [NCORES-1:0]   g_oh;
  logic                op_wr;

  logic [NCORES-1:0]   req;
  logic [NCORES-1:0]   grant;
  logic                grant_valid;
  logic [PW-1:0]       win_idx;
  logic [AW-1:0]       win_addr;
  logic [DW-1:0]       win_din;
  logic                win_wr;

  assign req = rden | wren;

  rr_pick #(
    .N  (NCORES),
    .PW (PW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .valid (grant_valid)
  );

  // Decode the one-hot grant into the winner's index, address, data and op.
  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    win_din  = '0;
    win_wr   = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      if (grant[i]) begin
        win_idx  = PW'(i);
        win_addr = Address[i*AW +: AW];
        win_din  = Din[i*DW +: DW];
        win_wr   = wren[i];
      end
    end
  end

  // Arbitration FSM; every output except busy/dbg_state is a register here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FREE;
      ptr        <= '0;
      g          <= '0;
      g_oh       <= '0;
      op_wr      <= 1'b0;
      acq        <= '0;
      Dq         <= '0;
      RAMAddress <= '0;
      RAMDin     <= '0;
      RAMwren    <= 1'b0;
    end else begin
      acq     <= '0;
      RAMwren <= 1'b0;
      case (state)
        FREE: begin
          if (grant_valid) begin
            g          <= win_idx;
            g_oh       <= grant;
            op_wr      <= win_wr;
            RAMAddress <= win_addr;
            RAMDin     <= win_din;
            RAMwren    <= win_wr;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // A write is committed by the RAM at the end of this cycle, so it
          // can complete immediately; a read still needs its data cycle.
          if (op_wr) begin
            acq   <= g_oh;
            state <= DONE;
          end else begin
            state <= WAITQ;
          end
        end
        WAITQ: begin
          Dq    <= RAMq;
          acq   <= g_oh;
          state <= DONE;
        end
        DONE: begin
          ptr   <= (g == PW'(NCORES - 1)) ? '0 : g + 1'b1;
          state <= FREE;
        end
        default: state <= FREE;
      endcase
    end
  end

  assign busy      = (state != FREE);
  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_arbiter4.sv
// Bench for dmem_arbiter4: a behavioural single-port RAM, directed stimulus
// with hand-computed expectations queued per transaction, and a monitor that
// checks every acq pulse against the head of the queue.
module tb_dmem_arbiter4;
  import dmem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [3:0]  rden    = '0;
  logic [3:0]  wren    = '0;
  logic [31:0] address = '0;
  logic [31:0] din     = '0;
  logic [7:0]  ramq    = '0;
  logic [3:0]  acq;
  logic [7:0]  dq;
  logic        busy;
  logic [7:0]  ramaddress;
  logic [7:0]  ramdin;
  logic        ramwren;
  logic [1:0]  dbg_state;

  dmem_arbiter4 #(.NCORES(4), .AW(8), .DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rden       (rden),
    .wren       (wren),
    .Address    (address),
    .Din        (din),
    .RAMq       (ramq),
    .acq        (acq),
    .Dq         (dq),
    .busy       (busy),
    .RAMAddress (ramaddress),
    .RAMDin     (ramdin),
    .RAMwren    (ramwren),
    .dbg_state  (dbg_state)
  );

  // Single-port synchronous RAM: read data one cycle after the address.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    ramq <= mem[ramaddress];
    if (ramwren) mem[ramaddress] = ramdin;
  end

  // ---------------- scoreboard ----------------
  // entry = {expected cycle of acq, expected acq, expected Dq}
  logic [43:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [43:0] e;
    if (acq !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_acq: got acq=%b at cycle %0d, expected no pulse", acq, cyc);
      end else begin
        e = exp_q.pop_front();
        check("acq_cycle", cyc, e[43:12]);
        check("acq_grant", {28'd0, acq}, {28'd0, e[11:8]});
        check("dq", {24'd0, dq}, {24'd0, e[7:0]});
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h5F;
    mem[8'h20] = 8'h00;
    mem[8'h30] = 8'h99;
    mem[8'h40] = 8'h11;
    mem[8'h41] = 8'h22;
    mem[8'h42] = 8'h33;
    mem[8'h43] = 8'h44;
    mem[8'h50] = 8'h5A;
    mem[8'h53] = 8'hC3;
    mem[8'h60] = 8'h01;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_acq",        {28'd0, acq}, 32'd0);
    check("rst_dq",         {24'd0, dq}, 32'd0);
    check("rst_busy",       {31'd0, busy}, 32'd0);
    check("rst_ramaddress", {24'd0, ramaddress}, 32'd0);
    check("rst_ramdin",     {24'd0, ramdin}, 32'd0);
    check("rst_ramwren",    {31'd0, ramwren}, 32'd0);
    check("rst_state",      {30'd0, dbg_state}, {30'd0, FREE});
    next_cycle();
    rst = 1'b0;

    // Core2 reads 0x10 (=0xA5); a core1 request raised only during ISSUE
    // and withdrawn again must be ignored.
    next_cycle();
    rden = 4'b0100;
    address[16 +: 8] = 8'h10;
    n = cyc;
    exp_q.push_back({32'(n + 3), 4'b0100, 8'hA5});
    next_cycle();
    rden = 4'b0010;
    address[8 +: 8] = 8'h11;
    next_cycle();
    rden = 4'b0000;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("idle_busy_after_read", {31'd0, busy}, 32'd0);

    // Core0 writes 0x3C to 0x20: strobe for exactly one cycle, acq at N+2,
    // Dq keeps the previous read value.
    next_cycle();
    wren = 4'b0001;
    address[0 +: 8] = 8'h20;
    din[0 +: 8] = 8'h3C;
    n = cyc;
    exp_q.push_back({32'(n + 2), 4'b0001, 8'hA5});
    @(negedge clk);
    check("wr_ramwren_n", {31'd0, ramwren}, 32'd0);
    next_cycle();
    wren = 4'b0000;
    @(negedge clk);
    check("wr_ramwren_n1",    {31'd0, ramwren}, 32'd1);
    check("wr_ramaddress_n1", {24'd0, ramaddress}, 32'h20);
    check("wr_ramdin_n1",     {24'd0, ramdin}, 32'h3C);
    check("wr_busy_n1",       {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("wr_ramwren_n2", {31'd0, ramwren}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("wr_mem_20", {24'd0, mem[8'h20]}, 32'h3C);
    check("idle_ramaddress_held", {24'd0, ramaddress}, 32'h20);

    // All four cores read after reset: served 0,1,2,3 four cycles apart.
    pulse_reset();
    @(negedge clk);
    check("rst2_dq", {24'd0, dq}, 32'd0);
    next_cycle();
    rden = 4'b1111;
    address = {8'h43, 8'h42, 8'h41, 8'h40};
    n = cyc;
    exp_q.push_back({32'(n + 3),  4'b0001, 8'h11});
    exp_q.push_back({32'(n + 7),  4'b0010, 8'h22});
    exp_q.push_back({32'(n + 11), 4'b0100, 8'h33});
    exp_q.push_back({32'(n + 15), 4'b1000, 8'h44});
    repeat (16) @(posedge clk);
    #1;
    rden = 4'b0000;
    repeat (2) @(posedge clk);

    // Core1 with rden and wren together is a write; Dq stays 0x44.
    next_cycle();
    rden = 4'b0010;
    wren = 4'b0010;
    address[8 +: 8] = 8'h30;
    din[8 +: 8] = 8'h77;
    n = cyc;
    exp_q.push_back({32'(n + 2), 4'b0010, 8'h44});
    next_cycle();
    rden = 4'b0000;
    wren = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("rdwr_mem_30", {24'd0, mem[8'h30]}, 32'h77);

    // Cores 0 and 3 request continuously after reset: grants 0,3,0,3.
    pulse_reset();
    next_cycle();
    rden = 4'b1001;
    address = {8'h53, 8'h00, 8'h00, 8'h50};
    n = cyc;
    exp_q.push_back({32'(n + 3),  4'b0001, 8'h5A});
    exp_q.push_back({32'(n + 7),  4'b1000, 8'hC3});
    exp_q.push_back({32'(n + 11), 4'b0001, 8'h5A});
    exp_q.push_back({32'(n + 15), 4'b1000, 8'hC3});
    repeat (16) @(posedge clk);
    #1;
    rden = 4'b0000;
    repeat (2) @(posedge clk);

    // Reset during ISSUE of a core2 write: strobe drops, no acq, back to FREE.
    next_cycle();
    wren = 4'b0100;
    address[16 +: 8] = 8'h60;
    din[16 +: 8] = 8'hEE;
    next_cycle();
    wren = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_ramwren_issue", {31'd0, ramwren}, 32'd1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ramwren", {31'd0, ramwren}, 32'd0);
    check("rstmid_busy",    {31'd0, busy}, 32'd0);
    check("rstmid_acq",     {28'd0, acq}, 32'd0);
    check("rstmid_state",   {30'd0, dbg_state}, {30'd0, FREE});
    repeat (5) @(posedge clk);

    @(negedge clk);
    check("pending_expectations", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter4.md
DMEM_ARBITER4 -- requirements
Module: dmem_arbiter4

Interface
REQ-001 The block SHALL have parameter NCORES, default 4, giving the number of requesting cores.
REQ-002 The block SHALL have parameter AW, default 8, giving the RAM address width.
REQ-003 The block SHALL have parameter DW, default 8, giving the RAM data width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port rden, input, NCORES bits: per-core read request.
REQ-007 The block SHALL have port wren, input, NCORES bits: per-core write request.
REQ-008 The block SHALL have port Address, input, NCORES*AW bits: core i address at [i*AW +: AW].
REQ-009 The block SHALL have port Din, input, NCORES*DW bits: core i write data at [i*DW +: DW].
REQ-010 The block SHALL have port RAMq, input, DW bits: RAM read data, valid one cycle after address is presented.
REQ-011 The block SHALL have port acq, output, NCORES bits: one-hot, one-cycle completion pulse to the served core.
REQ-012 The block SHALL have port Dq, output, DW bits: read data of the last completed read.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not FREE.
REQ-014 The block SHALL have ports RAMAddress (AW), RAMDin (DW) and RAMwren (1), all registered outputs driving the single-port RAM.

Function
REQ-015 Core i requests when rden[i]|wren[i]; if both are set, the access SHALL be a write.
REQ-016 The FSM SHALL have states FREE, ISSUE, WAITQ and DONE.
REQ-017 FREE: when any request is present, the block SHALL pick winner g round-robin, with priority order ptr, ptr+1, ... mod NCORES; latch g, op, address and data; load RAMAddress/RAMDin; set RAMwren=1 for a write; go to ISSUE. Otherwise it SHALL stay in FREE.
REQ-018 ISSUE: the block SHALL clear RAMwren on exit, go to WAITQ for a read, and go to DONE for a write.
REQ-019 WAITQ: the block SHALL capture RAMq into Dq at the end of the cycle and go to DONE.
REQ-020 DONE: acq SHALL equal one-hot(g) for this cycle only, ptr SHALL load (g+1) mod NCORES, and the next state SHALL be FREE.
REQ-021 Latency: with a request in FREE at cycle N, acq SHALL be high at N+3 for a read and N+2 for a write; RAMwren SHALL be high exactly during cycle N+1.
REQ-022 Requests SHALL be sampled only in FREE; input changes during service SHALL be ignored.
REQ-023 A requester SHALL deassert its request in the cycle after acq; a request held longer is treated as a new request.
REQ-024 A request withdrawn before being latched SHALL have no effect.
REQ-025 Dq SHALL hold its value except in WAITQ; write completion SHALL leave Dq unchanged.
REQ-026 RAMAddress and RAMDin SHALL hold their last values when idle; RAMwren SHALL be 0 outside ISSUE.

Reset
REQ-027 While rst is high, on the clock edge: state=FREE, ptr=0, acq=0, Dq=0, busy=0, RAMAddress=0, RAMDin=0, RAMwren=0.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no acq pulse; rst SHALL dominate any pending RAMwren.

Structure
REQ-029 Package dmem_arb_pkg SHALL hold the state enumeration and the NCORES/AW/DW defaults.
REQ-030 Sub-module rr_pick (combinational: request vector + ptr -> one-hot grant + valid) SHALL implement round-robin selection.

Verification
REQ-031 Core2 reads 0x10 with RAM[0x10]=0xA5 -> acq=4'b0100 at N+3, Dq=0xA5.
REQ-032 Core0 writes 0x3C to 0x20 -> RAMwren=1, RAMAddress=0x20, RAMDin=0x3C for one cycle; acq=4'b0001 at N+2.
REQ-033 All four cores read after reset -> acq order core0, 1, 2, 3, pulses 4 cycles apart, each Dq matching its RAM word.
REQ-034 Core1 asserts rden and wren together with Din=0x77 -> write performed, RAM holds 0x77, Dq unchanged.
REQ-035 Cores 0 and 3 re-request continuously -> grants alternate 0, 3, 0, 3.
REQ-036 rst asserted during ISSUE of a write -> RAMwren=0 next cycle, no acq, busy=0, state FREE.
